pulse_capture_ctrl: RTL and testbench

Parametrised multi-channel pulse-capture controller that sits between the ADC sample driver and the SPI readout path. It holds a frame-aligned pre-trigger ring buffer and detects a pulse as N consecutive "hot" frames on selected channels. After a trigger it collects a fixed number of post-trigger frames, then streams the whole capture out over a ready/valid interface. It re-arms automatically while `arm` is held.

---
 rtl/pulse_capture_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pulse_capture_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_capture_ctrl.sv
// Multi-channel pulse capture: frame-aligned pre/post-trigger ring buffer streamed out over ready/valid.
// Define PULSE_CAPTURE_HEADER_EN to prefix each capture with a pre_cnt header word.
module pulse_capture_ctrl #(
  parameter int                NUM_CH      = 4,
  parameter int                DATA_W      = 16,
  parameter int                PRE_FRAMES  = 500,
  parameter int                POST_FRAMES = 500,
  parameter int                VALID_COUNT = 20,
  parameter logic [DATA_W-1:0] THRESH      = DATA_W'(32),
  parameter logic [DATA_W-1:0] NEG_LIMIT   = DATA_W'(16'hF800),
  parameter logic [NUM_CH-1:0] TRIG_MASK   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              frame_err,
  output logic [1:0]        state_dbg
);

  // Readout handshake: a word moves on any cycle with m_valid && m_ready. Once m_valid
  // is high, m_data/m_last hold and m_valid stays high until that transfer happens.
  // The sample side has no ready: s_valid samples are taken or dropped, never stalled.

  localparam int DEPTH = (PRE_FRAMES + POST_FRAMES) * NUM_CH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = $clog2(PRE_FRAMES + 1);
  localparam int HW    = $clog2(VALID_COUNT + 1);
  localparam int QW    = (POST_FRAMES > 1) ? $clog2(POST_FRAMES) : 1;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_READOUT = 2'd3} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     ch;
  logic              frame_hot, aligned;
  logic [AW-1:0]     wr_ptr, frame_start, rd_ptr;
  logic [PW-1:0]     pre_cnt;
  logic [HW-1:0]     hot_cnt;
  logic [QW-1:0]     post_cnt;
  logic [LW-1:0]     rd_left;
  logic              rd_pend, pend_last;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ch_last, frame_end, bad, good_end, sample_hot, frame_is_hot;
  logic              writing, wr_en, end_ok, trigger, post_done;
  logic              load, issue, xfer_last;
  logic [AW-1:0]     wr_ptr_inc, rd_ptr_inc, start_ptr_n;
  logic [PW-1:0]     pre_cnt_n;
  logic [HW-1:0]     hot_cnt_n;
  logic [AW:0]       pre_words, start_sum;

  assign ch_last      = (ch == CW'(NUM_CH - 1));
  assign frame_end    = s_last || ch_last;
  assign bad          = s_valid && (s_last != ch_last);
  assign good_end     = s_valid && s_last && ch_last;
  assign sample_hot   = (s_data >= THRESH) && (s_data < NEG_LIMIT) && TRIG_MASK[ch];
  assign frame_is_hot = frame_hot || sample_hot;

  // A frame is only stored if its first channel was stored, so a capture that starts
  // mid-frame never shifts channel alignment in the ring.
  assign writing   = (state == S_ARMED) || (state == S_POST);
  assign wr_en     = writing && s_valid && !bad && ((ch == '0) || aligned);
  assign end_ok    = wr_en && good_end;
  assign wr_ptr_inc = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_inc = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  assign pre_cnt_n = (pre_cnt == PW'(PRE_FRAMES)) ? pre_cnt : pre_cnt + 1'b1;
  assign hot_cnt_n = frame_is_hot ? hot_cnt + 1'b1 : '0;
  assign trigger   = (state == S_ARMED) && arm && end_ok && (hot_cnt_n == HW'(VALID_COUNT));
  assign post_done = (state == S_POST) && end_ok && (post_cnt == QW'(POST_FRAMES - 1));

  // Oldest retained word: step back pre_cnt frames from the end of the trigger frame.
  assign pre_words   = (AW + 1)'(int'(pre_cnt_n) * NUM_CH);
  assign start_sum   = {1'b0, wr_ptr_inc} + (AW + 1)'(DEPTH) - pre_words;
  assign start_ptr_n = (start_sum >= (AW + 1)'(DEPTH)) ? AW'(start_sum - (AW + 1)'(DEPTH))
                                                       : AW'(start_sum);

  assign load      = rd_pend && (!m_valid || m_ready);
  assign issue     = (state == S_READOUT) && (rd_left != '0) && (!rd_pend || load);
  assign xfer_last = m_valid && m_ready && m_last;

  assign busy      = (state == S_POST) || (state == S_READOUT);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (arm) state_n = S_ARMED;
      S_ARMED:   if (!arm) state_n = S_IDLE;
                 else if (trigger) state_n = S_POST;
      S_POST:    if (post_done) state_n = S_READOUT;
      S_READOUT: if (xfer_last) state_n = arm ? S_ARMED : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
    if (issue) mem_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch          <= '0;
      frame_hot   <= 1'b0;
      aligned     <= 1'b0;
      frame_err   <= 1'b0;
      wr_ptr      <= '0;
      frame_start <= '0;
      rd_ptr      <= '0;
      pre_cnt     <= '0;
      hot_cnt     <= '0;
      post_cnt    <= '0;
      rd_left     <= '0;
      rd_pend     <= 1'b0;
      pend_last   <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
    end else begin
      if (s_valid) begin
        ch        <= frame_end ? '0 : ch + 1'b1;
        frame_hot <= frame_end ? 1'b0 : frame_is_hot;
      end
      if (bad) frame_err <= 1'b1;

      if (!writing)     aligned <= 1'b0;
      else if (s_valid) aligned <= !frame_end && wr_en;

      if (!writing || bad) wr_ptr <= frame_start;
      else if (wr_en)      wr_ptr <= wr_ptr_inc;
      if (end_ok) frame_start <= wr_ptr_inc;

      case (state)
        S_ARMED: begin
          if (!arm) begin
            pre_cnt <= '0;
            hot_cnt <= '0;
          end else if (bad) begin
            hot_cnt <= '0;
          end else if (end_ok) begin
            pre_cnt <= pre_cnt_n;
            hot_cnt <= trigger ? '0 : hot_cnt_n;
          end
        end
        S_POST: if (end_ok) post_cnt <= post_cnt + 1'b1;
        S_READOUT: if (xfer_last) begin
          pre_cnt <= '0;
          hot_cnt <= '0;
        end
        default: begin
          pre_cnt <= '0;
          hot_cnt <= '0;
        end
      endcase

      if (trigger) begin
        rd_ptr   <= start_ptr_n;
        post_cnt <= '0;
      end
      if (post_done) rd_left <= LW'((int'(pre_cnt) + POST_FRAMES) * NUM_CH);

      if (issue) begin
        rd_ptr    <= rd_ptr_inc;
        rd_left   <= rd_left - 1'b1;
        pend_last <= (rd_left == LW'(1));
        rd_pend   <= 1'b1;
      end else if (load) begin
        rd_pend   <= 1'b0;
      end

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= mem_q;
        m_last  <= pend_last;
`ifdef PULSE_CAPTURE_HEADER_EN
      end else if (post_done) begin
        m_valid <= 1'b1;
        m_data  <= DATA_W'(pre_cnt);
        m_last  <= 1'b0;
`endif
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_capture_ctrl.sv
// Directed bench for pulse_capture_ctrl: expected words queued at stimulus time, popped by a monitor.
module tb_pulse_capture_ctrl;

  localparam int DATA_W = 16;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_POST = 2'd2, ST_READOUT = 2'd3;

  logic              clk, rst, arm, s_valid, s_last, m_valid, m_ready, m_last, busy, frame_err;
  logic [DATA_W-1:0] s_data, m_data;
  logic [1:0]        state_dbg;

  logic [DATA_W:0]   exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              ready_toggle = 1'b0;

  pulse_capture_ctrl #(
    .NUM_CH(2), .DATA_W(DATA_W), .PRE_FRAMES(4), .POST_FRAMES(3), .VALID_COUNT(2),
    .THRESH(16'd32), .NEG_LIMIT(16'hF800), .TRIG_MASK(2'b11)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_toggle ? ~m_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic            stall_prev;
    logic [DATA_W:0] stall_word, want;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!m_valid || {m_last, m_data} !== stall_word) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b last=%b data=%h expected valid=1 last=%b data=%h",
                     m_valid, m_last, m_data, stall_word[DATA_W], stall_word[DATA_W-1:0]);
          end
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word: got unexpected last=%b data=%h expected no word", m_last, m_data);
          end else begin
            want = exp_q.pop_front();
            if ({m_last, m_data} !== want) begin
              errors++;
              $display("FAIL word: got last=%b data=%h expected last=%b data=%h",
                       m_last, m_data, want[DATA_W], want[DATA_W-1:0]);
            end
          end
        end
        stall_prev = m_valid && !m_ready;
        stall_word = {m_last, m_data};
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_sample(input logic [DATA_W-1:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    drive_sample(a, 1'b0);
    drive_sample(b, 1'b1);
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic last);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({last, b});
  endtask

  task automatic push_header(input int pre);
`ifdef PULSE_CAPTURE_HEADER_EN
    exp_q.push_back({1'b0, DATA_W'(pre)});
`else
    if (pre < 0) exp_q.push_back('0);
`endif
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check(name, exp_q.size(), 0);
    idle(3);
  endtask

  task automatic check_first_valid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 3) begin @(posedge clk); #1; n++; end
    check(name, m_valid, 1'b1);
  endtask

  // post frames base..base+5, then READOUT entry and first-word latency
  task automatic post_and_readout(input string tag, input logic [DATA_W-1:0] base);
    check({tag, "_post_state"}, state_dbg, ST_POST);
    check({tag, "_post_busy"}, busy, 1'b1);
    send_frame(base, base + 16'd1);
    send_frame(base + 16'd2, base + 16'd3);
    send_frame(base + 16'd4, base + 16'd5);
    check({tag, "_readout_state"}, state_dbg, ST_READOUT);
    check_first_valid({tag, "_first_valid"});
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(1);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_m_last", m_last, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    // normal capture: 6 quiet frames, 2 hot, 3 post -> last 4 pre frames + post
    arm = 1'b1;
    idle(2);
    check("armed_state", state_dbg, ST_ARMED);
    for (int k = 0; k < 12; k += 2) send_frame(16'(k), 16'(k + 1));
    send_frame(16'd100, 16'd20);
    check("one_hot_no_trig", state_dbg, ST_ARMED);
    push_header(4);
    push_frame(16'd8, 16'd9, 1'b0);
    push_frame(16'd10, 16'd11, 1'b0);
    push_frame(16'd100, 16'd20, 1'b0);
    push_frame(16'd100, 16'd21, 1'b0);
    push_frame(16'd40, 16'd41, 1'b0);
    push_frame(16'd42, 16'd43, 1'b0);
    push_frame(16'd44, 16'd45, 1'b1);
    send_frame(16'd100, 16'd21);
    post_and_readout("normal", 16'd40);
    wait_drain("normal_drain", 200);
    check("normal_rearm", state_dbg, ST_ARMED);
    check("normal_busy_low", busy, 1'b0);

    // early trigger with window-edge values (32 and F7FF are hot)
    send_frame(16'd32, 16'd1);
    push_header(2);
    push_frame(16'd32, 16'd1, 1'b0);
    push_frame(16'hF7FF, 16'd2, 1'b0);
    push_frame(16'd50, 16'd51, 1'b0);
    push_frame(16'd52, 16'd53, 1'b0);
    push_frame(16'd54, 16'd55, 1'b1);
    send_frame(16'hF7FF, 16'd2);
    post_and_readout("early", 16'd50);
    wait_drain("early_drain", 200);

    // no trigger: hot, quiet (31 / F800), hot, F900 (not hot)
    send_frame(16'd100, 16'd1);
    send_frame(16'd31, 16'hF800);
    send_frame(16'd100, 16'd2);
    send_frame(16'hF900, 16'd3);
    idle(2);
    check("notrig_state", state_dbg, ST_ARMED);
    check("notrig_busy", busy, 1'b0);

    // backpressure with frames fed during READOUT
    ready_toggle = 1'b1;
    send_frame(16'd100, 16'd8);
    push_header(4);
    push_frame(16'd100, 16'd2, 1'b0);
    push_frame(16'hF900, 16'd3, 1'b0);
    push_frame(16'd100, 16'd8, 1'b0);
    push_frame(16'd100, 16'd9, 1'b0);
    push_frame(16'd60, 16'd61, 1'b0);
    push_frame(16'd62, 16'd63, 1'b0);
    push_frame(16'd64, 16'd65, 1'b1);
    send_frame(16'd100, 16'd9);
    post_and_readout("bp", 16'd60);
    for (int i = 0; i < 5; i++) send_frame(16'(300 + 2 * i), 16'(301 + 2 * i));
    check("bp_still_readout", state_dbg, ST_READOUT);
    wait_drain("bp_drain", 300);
    ready_toggle = 1'b0;
    idle(1);

    send_frame(16'd100, 16'd11);
    push_header(2);
    push_frame(16'd100, 16'd11, 1'b0);
    push_frame(16'd100, 16'd12, 1'b0);
    push_frame(16'd70, 16'd71, 1'b0);
    push_frame(16'd72, 16'd73, 1'b0);
    push_frame(16'd74, 16'd75, 1'b1);
    send_frame(16'd100, 16'd12);
    post_and_readout("after_bp", 16'd70);
    wait_drain("after_bp_drain", 200);

    // frame error: short frame between two hot frames breaks the run
    send_frame(16'd100, 16'd1);
    drive_sample(16'd100, 1'b1);
    check("ferr_set", frame_err, 1'b1);
    send_frame(16'd100, 16'd2);
    check("ferr_hot_cleared", state_dbg, ST_ARMED);
    push_header(3);
    push_frame(16'd100, 16'd1, 1'b0);
    push_frame(16'd100, 16'd2, 1'b0);
    push_frame(16'd100, 16'd3, 1'b0);
    push_frame(16'd80, 16'd81, 1'b0);
    push_frame(16'd82, 16'd83, 1'b0);
    push_frame(16'd84, 16'd85, 1'b1);
    send_frame(16'd100, 16'd3);
    post_and_readout("ferr", 16'd80);
    wait_drain("ferr_drain", 200);
    check("ferr_sticky", frame_err, 1'b1);

    // reset in the middle of READOUT
    send_frame(16'd100, 16'd1);
    push_header(2);
    push_frame(16'd100, 16'd1, 1'b0);
    push_frame(16'd100, 16'd2, 1'b0);
    push_frame(16'd90, 16'd91, 1'b0);
    push_frame(16'd92, 16'd93, 1'b0);
    push_frame(16'd94, 16'd95, 1'b1);
    send_frame(16'd100, 16'd2);
    post_and_readout("rst_mid", 16'd90);
    begin
      int n;
      int start_sz;
      n = 0;
      start_sz = exp_q.size();
      while (exp_q.size() > start_sz - 3 && n < 50) begin @(negedge clk); n++; end
      check("rst_mid_progress", (exp_q.size() <= start_sz - 3), 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_m_valid", m_valid, 1'b0);
    check("rst_mid_m_last", m_last, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_frame_err", frame_err, 1'b0);
    check("rst_mid_state", state_dbg, ST_IDLE);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    arm = 1'b0;
    idle(20);
    check("post_rst_idle", state_dbg, ST_IDLE);
    check("post_rst_no_valid", m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
